// File: rtl/c2c_fifo_drain_packer.sv
// Drains the 21-bit C2C transfer FIFO and packs up to three entries per 63-bit link beat.
// Optional per-slot parity output enabled by defining C2C_PACK_PARITY_EN.
module c2c_fifo_drain_packer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FIFO_EMPTY,
  input  logic [20:0] FIFO_RDATA,
  output logic        FIFO_RDEN,
  input  logic        FLUSH,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [62:0] TX_DATA,
  output logic [1:0]  TX_WCNT,
`ifdef C2C_PACK_PARITY_EN
  output logic [2:0]  TX_PAR,
`endif
  output logic        IDLE
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t             r_state;
  logic [1:0]         r_wcnt;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic [62:0]        r_data;
  logic [1:0]         r_tx_wcnt;
  logic               r_tx_valid;
`ifdef C2C_PACK_PARITY_EN
  logic [2:0]         r_par;
  logic               w_word_par;
  assign w_word_par = ^FIFO_RDATA;
  assign TX_PAR     = r_par;
`endif

  logic       w_pop;
  logic [1:0] w_wcnt_nxt;
  logic       w_emit;

  assign w_pop      = (r_state == ST_ACC) && !FIFO_EMPTY;
  assign w_wcnt_nxt = r_wcnt + 2'(w_pop);
  // A pop always beats a timeout; FLUSH only acts once something is already held.
  assign w_emit     = (r_state == ST_ACC) &&
                      ((w_pop && (r_wcnt == 2'd2)) ||
                       ((r_wcnt != 2'd0) && (FLUSH || (!w_pop && (r_idle_cnt == TO_LAST)))));

  assign FIFO_RDEN = w_pop;
  assign TX_VALID  = r_tx_valid;
  assign TX_DATA   = r_data;
  assign TX_WCNT   = r_tx_wcnt;
  assign IDLE      = (r_state == ST_ACC) && (r_wcnt == 2'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_ACC;
      r_wcnt     <= 2'd0;
      r_idle_cnt <= '0;
      r_data     <= '0;
      r_tx_wcnt  <= 2'd0;
      r_tx_valid <= 1'b0;
`ifdef C2C_PACK_PARITY_EN
      r_par      <= 3'b000;
`endif
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_pop) begin
            case (r_wcnt)
              2'd0:    r_data[20:0]  <= FIFO_RDATA;
              2'd1:    r_data[41:21] <= FIFO_RDATA;
              default: r_data[62:42] <= FIFO_RDATA;
            endcase
`ifdef C2C_PACK_PARITY_EN
            case (r_wcnt)
              2'd0:    r_par[0] <= w_word_par;
              2'd1:    r_par[1] <= w_word_par;
              default: r_par[2] <= w_word_par;
            endcase
`endif
            r_idle_cnt <= '0;
          end else if (r_wcnt == 2'd0) begin
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
          end
          r_wcnt <= w_wcnt_nxt;
          if (w_emit) begin
            r_state    <= ST_OUT;
            r_tx_wcnt  <= w_wcnt_nxt;
            r_tx_valid <= 1'b1;
            r_idle_cnt <= '0;
          end
        end
        ST_OUT: begin
          // Beat is frozen until the transmitter takes it.
          if (TX_READY) begin
            r_state    <= ST_ACC;
            r_wcnt     <= 2'd0;
            r_data     <= '0;
            r_tx_wcnt  <= 2'd0;
            r_tx_valid <= 1'b0;
`ifdef C2C_PACK_PARITY_EN
            r_par      <= 3'b000;
`endif
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_c2c_fifo_drain_packer.sv
// Directed bench for c2c_fifo_drain_packer with a small FWFT FIFO model (TIMEOUT=4).
// Parity checks are compiled in when C2C_PACK_PARITY_EN is defined.
module tb_c2c_fifo_drain_packer;

  logic        CLK;
  logic        RST_N;
  logic        FIFO_EMPTY;
  logic [20:0] FIFO_RDATA;
  logic        FIFO_RDEN;
  logic        FLUSH;
  logic        TX_VALID;
  logic        TX_READY;
  logic [62:0] TX_DATA;
  logic [1:0]  TX_WCNT;
  logic        IDLE;
`ifdef C2C_PACK_PARITY_EN
  logic [2:0]  TX_PAR;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // FWFT FIFO model: head is mem[rd_ptr]; hold forces EMPTY to emulate gaps.
  logic [20:0] mem [0:255];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr;
  logic        hold;

  assign FIFO_EMPTY = (rd_ptr == wr_ptr) || hold;
  assign FIFO_RDATA = mem[rd_ptr];

  always @(posedge CLK) if (FIFO_RDEN) rd_ptr <= rd_ptr + 8'd1;

  c2c_fifo_drain_packer #(.TIMEOUT(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RDATA (FIFO_RDATA),
    .FIFO_RDEN  (FIFO_RDEN),
    .FLUSH      (FLUSH),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .TX_DATA    (TX_DATA),
    .TX_WCNT    (TX_WCNT),
`ifdef C2C_PACK_PARITY_EN
    .TX_PAR     (TX_PAR),
`endif
    .IDLE       (IDLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [20:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [62:0] exp_data;

  initial begin
    RST_N    = 1'b0;
    FLUSH    = 1'b0;
    TX_READY = 1'b0;
    hold     = 1'b0;
    wr_ptr   = 8'd0;
    #1;
    check("rst_valid", 64'(TX_VALID), 64'd0);
    check("rst_wcnt",  64'(TX_WCNT),  64'd0);
    check("rst_data",  64'(TX_DATA),  64'd0);
    check("rst_rden",  64'(FIFO_RDEN), 64'd0);
    check("rst_idle",  64'(IDLE),     64'd1);
`ifdef C2C_PACK_PARITY_EN
    check("rst_par",   64'(TX_PAR),   64'd0);
`endif
    nclk(2);
    RST_N = 1'b1;

    // Full pack: three pops back to back, one beat, then idle
    nclk(1);
    TX_READY = 1'b1;
    push(21'h000001); push(21'h000002); push(21'h000003);
    #1 check("full_rden0", 64'(FIFO_RDEN), 64'd1);
    nclk(1); check("full_rden1", 64'(FIFO_RDEN), 64'd1);
    check("full_novalid", 64'(TX_VALID), 64'd0);
    nclk(1); check("full_rden2", 64'(FIFO_RDEN), 64'd1);
    nclk(1);
    exp_data = {21'h000003, 21'h000002, 21'h000001};
    check("full_valid", 64'(TX_VALID), 64'd1);
    check("full_data",  64'(TX_DATA),  64'(exp_data));
    check("full_wcnt",  64'(TX_WCNT),  64'd3);
    check("full_idle_out", 64'(IDLE),  64'd0);
    nclk(1);
    check("full_done_valid", 64'(TX_VALID), 64'd0);
    check("full_done_idle",  64'(IDLE),     64'd1);

    // Backpressure: beat stalls 10 cycles with FIFO still non-empty
    TX_READY = 1'b0;
    push(21'h000011); push(21'h000022); push(21'h000033); push(21'h1ABCDE);
    nclk(3);
    exp_data = {21'h000033, 21'h000022, 21'h000011};
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(TX_VALID),  64'd1);
      check("bp_rden",  64'(FIFO_RDEN), 64'd0);
      check("bp_data",  64'(TX_DATA),   64'(exp_data));
      check("bp_wcnt",  64'(TX_WCNT),   64'd3);
      nclk(1);
    end
    TX_READY = 1'b1;
    nclk(1);
    check("bp_hs_valid", 64'(TX_VALID),  64'd0);
    check("bp_resume",   64'(FIFO_RDEN), 64'd1);

    // Timeout: lone word 0x1ABCDE popped on the next edge, emits 4 edges later
    nclk(1);
    check("to_wait0", 64'(TX_VALID), 64'd0);
    check("to_empty", 64'(FIFO_RDEN), 64'd0);
    nclk(3);
    check("to_wait3", 64'(TX_VALID), 64'd0);
    nclk(1);
    check("to_valid", 64'(TX_VALID), 64'd1);
    check("to_wcnt",  64'(TX_WCNT),  64'd1);
    check("to_upper", 64'(TX_DATA[62:21]), 64'd0);
    check("to_slot0", 64'(TX_DATA[20:0]),  64'h1ABCDE);
    nclk(1);
    check("to_done", 64'(IDLE), 64'd1);

    // Flush of a two-word partial beat
    push(21'h0AAAAA); push(21'h155555);
    nclk(2);
    check("fl_pre", 64'(TX_VALID), 64'd0);
    FLUSH = 1'b1;
    nclk(1);
    FLUSH = 1'b0;
    check("fl_valid", 64'(TX_VALID), 64'd1);
    check("fl_wcnt",  64'(TX_WCNT),  64'd2);
    check("fl_data",  64'(TX_DATA),  64'({21'h0, 21'h155555, 21'h0AAAAA}));
    nclk(1);
    check("fl_done", 64'(IDLE), 64'd1);
    FLUSH = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nclk(1);
      check("fl_idle_ignored", 64'(TX_VALID), 64'd0);
    end
    FLUSH = 1'b0;

    // Timeout and FLUSH on the same edge give exactly one beat
    push(21'h000123);
    nclk(4);
    check("tf_pre", 64'(TX_VALID), 64'd0);
    FLUSH = 1'b1;
    nclk(1);
    FLUSH = 1'b0;
    check("tf_valid", 64'(TX_VALID), 64'd1);
    check("tf_wcnt",  64'(TX_WCNT),  64'd1);
    nclk(1);
    check("tf_done", 64'(TX_VALID), 64'd0);
    nclk(1);
    check("tf_single", 64'(TX_VALID), 64'd0);

    // FIFO_EMPTY toggling: pops only in non-empty cycles, order preserved
    hold = 1'b1;
    push(21'h000005); push(21'h000006); push(21'h000007);
    #1 check("tg_blocked", 64'(FIFO_RDEN), 64'd0);
    for (int i = 0; i < 3; i++) begin
      nclk(1);
      hold = 1'b0;
      #1 check("tg_pop", 64'(FIFO_RDEN), 64'd1);
      nclk(1);
      hold = 1'b1;
      #1 check("tg_gap", 64'(FIFO_RDEN), 64'd0);
    end
    check("tg_valid", 64'(TX_VALID), 64'd1);
    check("tg_data",  64'(TX_DATA),  64'({21'h000007, 21'h000006, 21'h000005}));
    check("tg_wcnt",  64'(TX_WCNT),  64'd3);
    hold = 1'b0;
    nclk(1);
    check("tg_done", 64'(IDLE), 64'd1);

    // Asynchronous reset in the middle of a presented beat
    TX_READY = 1'b0;
    push(21'h000111); push(21'h000222); push(21'h000333);
    nclk(3);
    check("rm_valid_pre", 64'(TX_VALID), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check("rm_valid", 64'(TX_VALID), 64'd0);
    check("rm_wcnt",  64'(TX_WCNT),  64'd0);
    check("rm_data",  64'(TX_DATA),  64'd0);
    check("rm_idle",  64'(IDLE),     64'd1);
    nclk(1);
    RST_N    = 1'b1;
    TX_READY = 1'b1;
    push(21'h000ABC);
    nclk(1);
    FLUSH = 1'b1;
    nclk(1);
    FLUSH = 1'b0;
    check("rm_after_wcnt", 64'(TX_WCNT), 64'd1);
    check("rm_after_data", 64'(TX_DATA), 64'h000ABC);
    nclk(1);

`ifdef C2C_PACK_PARITY_EN
    // Per-slot parity
    push(21'h000007); push(21'h000003); push(21'h000000);
    nclk(3);
    check("par_valid", 64'(TX_VALID), 64'd1);
    check("par_bits",  64'(TX_PAR),   64'd1);
    nclk(1);
    check("par_clear", 64'(TX_PAR),   64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c2c_fifo_drain_packer.md
Name: c2c_fifo_drain_packer

Overview:
- Downstream consumer of the 21-bit C2C transfer FIFO.
- The FIFO is first-word-fall-through: read data is valid whenever EMPTY=0, and RDEN pops the head entry on the clock edge.
- The block pops 21-bit entries and packs up to three of them into one 63-bit beat for the C2C link transmitter, using a valid/ready handshake.
- Partial beats are emitted on an idle timeout or on an explicit flush, so low-rate traffic is never stranded.

Parameters:
- TIMEOUT, 16: idle cycles with a partial beat held before a forced partial emit. Legal range 1..255.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- FIFO_EMPTY  in  1  FIFO empty flag; head data valid when 0
- FIFO_RDATA  in  21  FIFO head entry
- FIFO_RDEN  out  1  pop request to FIFO
- FLUSH  in  1  force emission of any partial beat
- TX_VALID  out  1  beat valid
- TX_READY  in  1  link transmitter accepts beat
- TX_DATA  out  63  packed beat; slot0=[20:0], slot1=[41:21], slot2=[62:42]
- TX_WCNT  out  2  number of valid slots in beat (1..3)
- IDLE  out  1  no words held and no beat pending

Behaviour:
- Reset (async, any time, including mid-beat): state=ACC, wcnt=0, idle counter=0, TX_DATA=0, TX_WCNT=0, TX_VALID=0, FIFO_RDEN=0, IDLE=1. Held words and any pending beat are discarded.
- States: ACC (accumulating, wcnt 0..2) and OUT (beat presented).
- FIFO_RDEN is combinational: FIFO_RDEN = (state==ACC) && !FIFO_EMPTY. No pops occur in OUT.
- On a clock edge with FIFO_RDEN=1:
  - FIFO_RDATA is written into slot[wcnt] and wcnt increments.
  - If wcnt was 2, the next state is OUT with TX_WCNT=3.
- Idle counter:
  - Cleared on every pop and whenever wcnt=0.
  - Otherwise increments each ACC cycle with no pop.
  - When the counter equals TIMEOUT-1 and wcnt>0, the next state is OUT with TX_WCNT=wcnt.
  - So a partial beat emits TIMEOUT cycles after the last pop.
- FLUSH, sampled in ACC:
  - wcnt>0 and no pop this cycle: next state is OUT with TX_WCNT=wcnt.
  - Pop in the same cycle: the popped word is included, then OUT follows. If wcnt reaches 3, TX_WCNT=3.
  - wcnt=0: FLUSH is ignored.
  - In OUT: FLUSH is ignored.
- Unfilled slots in a partial beat read as 0.
- OUT state:
  - TX_VALID=1.
  - TX_DATA and TX_WCNT are held stable until TX_VALID && TX_READY.
  - On the handshake edge: next state ACC, wcnt=0, slots cleared to 0, TX_WCNT=0, TX_VALID=0.
  - TX_READY may be low for an unbounded number of cycles; there is no data change and no timeout while stalled.
- TX_VALID is registered; there is no combinational path from TX_READY to any output.
- IDLE = (state==ACC) && (wcnt==0).
- Throughput: a full beat takes a minimum of 4 cycles (3 pops + 1 OUT cycle with TX_READY=1).
- Boundary conditions:
  - FIFO_EMPTY toggling between pops: pops only in non-empty cycles; slot order is preserved.
  - A timeout and FLUSH in the same cycle produce a single partial beat.
  - A timeout and a pop in the same cycle: the pop wins, the counter clears, and no emission occurs unless wcnt reaches 3.

Optional Feature:
- Macro: C2C_PACK_PARITY_EN.
- Defined:
  - Adds output port TX_PAR (3 bits, registered alongside TX_DATA).
  - TX_PAR[i] is the even parity (XOR reduce) of slot i.
  - Empty slots give parity 0.
  - Reset value is 0, and the port is held stable with TX_DATA.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Full pack: FIFO holds 0x000001, 0x000002, 0x000003, TX_READY=1 -> 3 consecutive RDEN pulses, then TX_VALID for 1 cycle with TX_DATA={0x000003,0x000002,0x000001} and TX_WCNT=3; IDLE=1 after.
- Backpressure: full beat with TX_READY=0 for 10 cycles while FIFO is non-empty -> FIFO_RDEN=0 and TX_DATA stable throughout; on TX_READY=1, one handshake, then pops resume next cycle.
- Timeout: TIMEOUT=4, single word 0x1ABCDE, then FIFO empty -> TX_VALID rises 4 cycles after the pop; TX_WCNT=1, TX_DATA[62:21]=0.
- Flush: 2 words 0x0AAAAA, 0x155555 popped, FLUSH pulsed next cycle -> beat next cycle with TX_WCNT=2, slot2=0. FLUSH with IDLE=1 -> no TX_VALID.
- Reset mid-beat: RST_N low while TX_VALID=1 with TX_WCNT=3 -> TX_VALID, TX_WCNT and TX_DATA go to 0 immediately (asynchronously); after release, the next word starts in slot0.
- Parity (C2C_PACK_PARITY_EN defined): slots 0x000007, 0x000003, 0x000000 -> TX_PAR=3'b001.
